// File: rtl/axi_to_lite_splitter.sv
// AXI4 to AXI-Lite burst splitter: each full-AXI burst becomes len+1 sequential
// single-beat AXI-Lite transactions; read and write paths run independently.

package axi_to_lite_pkg;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned UW = 8;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [AW-1:0]   addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic            lock;
    logic [3:0]      cache;
    logic [2:0]      prot;
    logic [3:0]      qos;
    logic [UW-1:0]   user;
  } ax_chan_t;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
    logic [UW-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [1:0]      resp;
    logic [UW-1:0]   user;
  } b_chan_t;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [DW-1:0]   data;
    logic [1:0]      resp;
    logic            last;
    logic [UW-1:0]   user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    prot;
  } lite_ax_t;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
  } lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } lite_b_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } lite_r_t;

  typedef struct packed {
    lite_ax_t aw;
    logic     aw_valid;
    lite_w_t  w;
    logic     w_valid;
    logic     b_ready;
    lite_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } lite_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    logic    b_valid;
    lite_b_t b;
    logic    ar_ready;
    logic    r_valid;
    lite_r_t r;
  } lite_resp_t;
endpackage

module axi_to_lite_splitter #(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 32,
  parameter int unsigned AxiIdWidth   = 8,
  parameter int unsigned AxiUserWidth = 8,
  parameter type axi_req_t   = axi_to_lite_pkg::axi_req_t,
  parameter type axi_resp_t  = axi_to_lite_pkg::axi_resp_t,
  parameter type lite_req_t  = axi_to_lite_pkg::lite_req_t,
  parameter type lite_resp_t = axi_to_lite_pkg::lite_resp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  axi_req_t   slv_req_i,
  output axi_resp_t  slv_resp_o,
  output lite_req_t  mst_req_o,
  input  lite_resp_t mst_resp_i
);

  localparam int unsigned MaxSize = $clog2(AxiDataWidth/8);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_BEAT, W_RESP, W_BRESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rstate_e;

  wstate_e                 wstate, wstate_n;
  logic [AxiIdWidth-1:0]   wid, wid_n;
  logic [AxiAddrWidth-1:0] waddr, waddr_n;
  logic [7:0]              wlen, wlen_n, wcnt, wcnt_n;
  logic [2:0]              wsize, wsize_n, wprot, wprot_n;
  logic [1:0]              wburst, wburst_n, wworst, wworst_n;
  logic                    woversize, woversize_n, awdone, awdone_n, wdone, wdone_n;

  rstate_e                 rstate, rstate_n;
  logic [AxiIdWidth-1:0]   rid, rid_n;
  logic [AxiAddrWidth-1:0] raddr, raddr_n;
  logic [7:0]              rlen, rlen_n, rcnt, rcnt_n;
  logic [2:0]              rsize, rsize_n, rprot, rprot_n;
  logic [1:0]              rburst, rburst_n;
  logic                    roversize, roversize_n;

  // Only a subset of the request/response fields is meaningful here.
  logic unused_inputs;
  assign unused_inputs = ^{slv_req_i, mst_resp_i};

  // Lite EXOKAY has no meaning without exclusive access; fold it into OKAY.
  function automatic logic [1:0] norm_resp(input logic [1:0] r);
    norm_resp = (r == RespExOkay) ? RespOkay : r;
  endfunction

  // After normalisation the encodings OKAY < SLVERR < DECERR order by severity.
  function automatic logic [1:0] worse_resp(input logic [1:0] cur, input logic [1:0] r);
    logic [1:0] n;
    n = norm_resp(r);
    worse_resp = (n > cur) ? n : cur;
  endfunction

  function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst,
                                                        input logic [7:0] len);
    logic [AxiAddrWidth-1:0] step, incr, wsize_b, base;
    step    = AxiAddrWidth'(1) << size;
    incr    = (addr & ~(step - AxiAddrWidth'(1))) + step;
    wsize_b = (AxiAddrWidth'(len) + AxiAddrWidth'(1)) << size;
    base    = addr & ~(wsize_b - AxiAddrWidth'(1));
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (incr >= base + wsize_b) ? base : incr;
      default: next_addr = incr;
    endcase
  endfunction

  // Next-state and output decode for both the write and the read FSM.
  always_comb begin
    slv_resp_o  = '0;
    mst_req_o   = '0;
    wstate_n    = wstate;
    wid_n       = wid;
    waddr_n     = waddr;
    wlen_n      = wlen;
    wcnt_n      = wcnt;
    wsize_n     = wsize;
    wprot_n     = wprot;
    wburst_n    = wburst;
    wworst_n    = wworst;
    woversize_n = woversize;
    awdone_n    = awdone;
    wdone_n     = wdone;
    rstate_n    = rstate;
    rid_n       = rid;
    raddr_n     = raddr;
    rlen_n      = rlen;
    rcnt_n      = rcnt;
    rsize_n     = rsize;
    rprot_n     = rprot;
    rburst_n    = rburst;
    roversize_n = roversize;

    slv_resp_o.b.user = AxiUserWidth'(0);

    case (wstate)
      W_IDLE: begin
        // Held low while in reset so no burst is accepted until release.
        slv_resp_o.aw_ready = rst_ni;
        if (slv_req_i.aw_valid) begin
          wid_n       = slv_req_i.aw.id;
          waddr_n     = slv_req_i.aw.addr;
          wlen_n      = slv_req_i.aw.len;
          wsize_n     = slv_req_i.aw.size;
          wburst_n    = slv_req_i.aw.burst;
          wprot_n     = slv_req_i.aw.prot;
          wcnt_n      = '0;
          woversize_n = 32'(slv_req_i.aw.size) > MaxSize;
          wworst_n    = woversize_n ? RespSlvErr : RespOkay;
          awdone_n    = 1'b0;
          wdone_n     = 1'b0;
          wstate_n    = W_BEAT;
        end
      end
      W_BEAT: begin
        if (woversize) begin
          // Oversize bursts just drain the W beats; no lite traffic.
          slv_resp_o.w_ready = 1'b1;
          if (slv_req_i.w_valid) begin
            if (wcnt == wlen) wstate_n = W_BRESP;
            else              wcnt_n   = wcnt + 8'd1;
          end
        end else begin
          mst_req_o.aw_valid = !awdone;
          mst_req_o.aw.addr  = waddr;
          mst_req_o.aw.prot  = wprot;
          mst_req_o.w_valid  = !wdone && slv_req_i.w_valid;
          mst_req_o.w.data   = slv_req_i.w.data;
          mst_req_o.w.strb   = slv_req_i.w.strb;
          slv_resp_o.w_ready = !wdone && mst_resp_i.w_ready;
          awdone_n = awdone | mst_resp_i.aw_ready;
          wdone_n  = wdone | (slv_req_i.w_valid & mst_resp_i.w_ready);
          if (awdone_n && wdone_n) wstate_n = W_RESP;
        end
      end
      W_RESP: begin
        mst_req_o.b_ready = 1'b1;
        if (mst_resp_i.b_valid) begin
          wworst_n = worse_resp(wworst, mst_resp_i.b.resp);
          if (wcnt == wlen) begin
            wstate_n = W_BRESP;
          end else begin
            wcnt_n   = wcnt + 8'd1;
            waddr_n  = next_addr(waddr, wsize, wburst, wlen);
            awdone_n = 1'b0;
            wdone_n  = 1'b0;
            wstate_n = W_BEAT;
          end
        end
      end
      default: begin
        slv_resp_o.b_valid  = 1'b1;
        slv_resp_o.b.id     = wid;
        slv_resp_o.b.resp   = wworst;
        if (slv_req_i.b_ready) wstate_n = W_IDLE;
      end
    endcase

    case (rstate)
      R_IDLE: begin
        slv_resp_o.ar_ready = rst_ni;
        if (slv_req_i.ar_valid) begin
          rid_n       = slv_req_i.ar.id;
          raddr_n     = slv_req_i.ar.addr;
          rlen_n      = slv_req_i.ar.len;
          rsize_n     = slv_req_i.ar.size;
          rburst_n    = slv_req_i.ar.burst;
          rprot_n     = slv_req_i.ar.prot;
          rcnt_n      = '0;
          roversize_n = 32'(slv_req_i.ar.size) > MaxSize;
          rstate_n    = roversize_n ? R_R : R_AR;
        end
      end
      R_AR: begin
        mst_req_o.ar_valid = 1'b1;
        mst_req_o.ar.addr  = raddr;
        mst_req_o.ar.prot  = rprot;
        if (mst_resp_i.ar_ready) rstate_n = R_R;
      end
      default: begin
        slv_resp_o.r.id   = rid;
        slv_resp_o.r.last = (rcnt == rlen);
        if (roversize) begin
          slv_resp_o.r_valid = 1'b1;
          slv_resp_o.r.resp  = RespSlvErr;
        end else begin
          slv_resp_o.r_valid = mst_resp_i.r_valid;
          slv_resp_o.r.data  = mst_resp_i.r.data;
          slv_resp_o.r.resp  = norm_resp(mst_resp_i.r.resp);
          mst_req_o.r_ready  = slv_req_i.r_ready;
        end
        if (slv_resp_o.r_valid && slv_req_i.r_ready) begin
          if (rcnt == rlen) begin
            rstate_n = R_IDLE;
          end else begin
            rcnt_n   = rcnt + 8'd1;
            raddr_n  = next_addr(raddr, rsize, rburst, rlen);
            rstate_n = roversize ? R_R : R_AR;
          end
        end
      end
    endcase
  end

  // State and burst-context registers; reset abandons any burst in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wstate    <= W_IDLE;
      wid       <= '0;
      waddr     <= '0;
      wlen      <= '0;
      wcnt      <= '0;
      wsize     <= '0;
      wprot     <= '0;
      wburst    <= '0;
      wworst    <= RespOkay;
      woversize <= 1'b0;
      awdone    <= 1'b0;
      wdone     <= 1'b0;
      rstate    <= R_IDLE;
      rid       <= '0;
      raddr     <= '0;
      rlen      <= '0;
      rcnt      <= '0;
      rsize     <= '0;
      rprot     <= '0;
      rburst    <= '0;
      roversize <= 1'b0;
    end else begin
      wstate    <= wstate_n;
      wid       <= wid_n;
      waddr     <= waddr_n;
      wlen      <= wlen_n;
      wcnt      <= wcnt_n;
      wsize     <= wsize_n;
      wprot     <= wprot_n;
      wburst    <= wburst_n;
      wworst    <= wworst_n;
      woversize <= woversize_n;
      awdone    <= awdone_n;
      wdone     <= wdone_n;
      rstate    <= rstate_n;
      rid       <= rid_n;
      raddr     <= raddr_n;
      rlen      <= rlen_n;
      rcnt      <= rcnt_n;
      rsize     <= rsize_n;
      rprot     <= rprot_n;
      rburst    <= rburst_n;
      roversize <= roversize_n;
    end
  end

endmodule

// File: tb/tb_axi_to_lite_splitter.sv
// Directed bench for axi_to_lite_splitter: single, INCR, WRAP, backpressure,
// concurrent, oversize and mid-burst reset scenarios.

module tb_axi_to_lite_splitter;
  import axi_to_lite_pkg::*;

  logic       clk;
  logic       rst_n;
  axi_req_t   slv_req;
  axi_resp_t  slv_resp;
  lite_req_t  mst_req;
  lite_resp_t mst_resp;

  int checks = 0;
  int errors = 0;
  int aw_hs  = 0;
  int ar_hs  = 0;
  int aw_base;
  int ar_base;

  axi_to_lite_splitter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count lite address handshakes to prove how many transactions were issued.
  always @(posedge clk) begin
    if (mst_req.aw_valid && mst_resp.aw_ready) aw_hs++;
    if (mst_req.ar_valid && mst_resp.ar_ready) ar_hs++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    slv_req.aw.id = id; slv_req.aw.addr = addr; slv_req.aw.len = len;
    slv_req.aw.size = size; slv_req.aw.burst = burst; slv_req.aw_valid = 1'b1;
    settle();
    check("aw_ready", 64'(slv_resp.aw_ready), 64'd1);
    tick();
    slv_req.aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    slv_req.ar.id = id; slv_req.ar.addr = addr; slv_req.ar.len = len;
    slv_req.ar.size = size; slv_req.ar.burst = burst; slv_req.ar_valid = 1'b1;
    settle();
    check("ar_ready", 64'(slv_resp.ar_ready), 64'd1);
    tick();
    slv_req.ar_valid = 1'b0;
  endtask

  // One lite write beat: expect AW at addr, pass W data, answer with bresp.
  task automatic wr_beat(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] bresp);
    slv_req.w_valid = 1'b1; slv_req.w.data = data; slv_req.w.strb = 4'hF;
    settle();
    check({tag, " lite aw_valid"}, 64'(mst_req.aw_valid), 64'd1);
    check({tag, " lite aw.addr"}, 64'(mst_req.aw.addr), 64'(addr));
    check({tag, " lite w.data"}, 64'(mst_req.w.data), 64'(data));
    check({tag, " lite w.strb"}, 64'(mst_req.w.strb), 64'hF);
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    tick();
    mst_resp.aw_ready = 1'b0; mst_resp.w_ready = 1'b0; slv_req.w_valid = 1'b0;
    mst_resp.b_valid = 1'b1; mst_resp.b.resp = bresp;
    settle();
    check({tag, " lite b_ready"}, 64'(mst_req.b_ready), 64'd1);
    tick();
    mst_resp.b_valid = 1'b0;
  endtask

  task automatic b_take(input string tag, input logic [7:0] id, input logic [1:0] resp);
    settle();
    check({tag, " b_valid"}, 64'(slv_resp.b_valid), 64'd1);
    check({tag, " b.id"}, 64'(slv_resp.b.id), 64'(id));
    check({tag, " b.resp"}, 64'(slv_resp.b.resp), 64'(resp));
    slv_req.b_ready = 1'b1;
    tick();
    slv_req.b_ready = 1'b0;
    settle();
    check({tag, " idle aw_ready"}, 64'(slv_resp.aw_ready), 64'd1);
  endtask

  // One lite read beat: expect AR at addr, return data, observe AXI R.
  task automatic rd_beat(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [7:0] id, input logic last);
    settle();
    check({tag, " lite ar_valid"}, 64'(mst_req.ar_valid), 64'd1);
    check({tag, " lite ar.addr"}, 64'(mst_req.ar.addr), 64'(addr));
    mst_resp.ar_ready = 1'b1;
    tick();
    mst_resp.ar_ready = 1'b0;
    mst_resp.r_valid = 1'b1; mst_resp.r.data = data; mst_resp.r.resp = 2'b00;
    slv_req.r_ready = 1'b1;
    settle();
    check({tag, " r_valid"}, 64'(slv_resp.r_valid), 64'd1);
    check({tag, " r.data"}, 64'(slv_resp.r.data), 64'(data));
    check({tag, " r.id"}, 64'(slv_resp.r.id), 64'(id));
    check({tag, " r.last"}, 64'(slv_resp.r.last), 64'(last));
    check({tag, " lite r_ready"}, 64'(mst_req.r_ready), 64'd1);
    tick();
    mst_resp.r_valid = 1'b0; slv_req.r_ready = 1'b0;
  endtask

  function automatic logic [9:0] all_hs();
    all_hs = {mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready, mst_req.ar_valid,
              mst_req.r_ready, slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready,
              slv_resp.b_valid, slv_resp.r_valid};
  endfunction

  initial begin
    rst_n = 1'b0;
    slv_req = '0;
    mst_resp = '0;
    slv_req.aw.prot = 3'b010;
    slv_req.ar.prot = 3'b001;

    // Reset state: every valid and ready low, including aw/ar ready.
    tick(); tick();
    check("reset handshakes", 64'(all_hs()), 64'd0);
    rst_n = 1'b1;
    settle();
    check("post-reset aw_ready", 64'(slv_resp.aw_ready), 64'd1);
    check("post-reset ar_ready", 64'(slv_resp.ar_ready), 64'd1);

    // Single write.
    aw_base = aw_hs;
    aw_send(8'h05, 32'h1000, 8'd0, 3'd2, 2'b01);
    settle();
    check("single lite aw.prot", 64'(mst_req.aw.prot), 64'h2);
    wr_beat("single", 32'h1000, 32'hDEADBEEF, 2'b00);
    b_take("single", 8'h05, 2'b00);
    check("single lite aw count", 64'(aw_hs - aw_base), 64'd1);

    // INCR write len 3 with one SLVERR and one EXOKAY beat.
    aw_base = aw_hs;
    aw_send(8'h11, 32'h2000, 8'd3, 3'd2, 2'b01);
    wr_beat("incr0", 32'h2000, 32'h0000_0000, 2'b01);
    wr_beat("incr1", 32'h2004, 32'h1111_1111, 2'b00);
    wr_beat("incr2", 32'h2008, 32'h2222_2222, 2'b10);
    wr_beat("incr3", 32'h200C, 32'h3333_3333, 2'b00);
    b_take("incr", 8'h11, 2'b10);
    check("incr lite aw count", 64'(aw_hs - aw_base), 64'd4);

    // WRAP read: 16-byte wrap window based at 0x3000.
    ar_base = ar_hs;
    ar_send(8'h03, 32'h3008, 8'd3, 3'd2, 2'b10);
    settle();
    check("wrap lite ar.prot", 64'(mst_req.ar.prot), 64'h1);
    rd_beat("wrap0", 32'h3008, 32'hA000_0000, 8'h03, 1'b0);
    rd_beat("wrap1", 32'h300C, 32'hA000_0001, 8'h03, 1'b0);
    rd_beat("wrap2", 32'h3000, 32'hA000_0002, 8'h03, 1'b0);
    rd_beat("wrap3", 32'h3004, 32'hA000_0003, 8'h03, 1'b1);
    settle();
    check("wrap idle ar_ready", 64'(slv_resp.ar_ready), 64'd1);
    check("wrap lite ar count", 64'(ar_hs - ar_base), 64'd4);

    // Backpressure: lite aw_ready late, AXI b_ready late, lite EXOKAY -> OKAY.
    aw_base = aw_hs;
    aw_send(8'h07, 32'h4000, 8'd0, 3'd2, 2'b01);
    slv_req.w_valid = 1'b1; slv_req.w.data = 32'h5555_AAAA; mst_resp.w_ready = 1'b1;
    settle();
    check("bp w_ready", 64'(slv_resp.w_ready), 64'd1);
    tick();
    slv_req.w_valid = 1'b0; mst_resp.w_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp aw_valid held", 64'(mst_req.aw_valid), 64'd1);
      check("bp aw.addr held", 64'(mst_req.aw.addr), 64'h4000);
      check("bp w_valid after hs", 64'(mst_req.w_valid), 64'd0);
      tick();
    end
    mst_resp.aw_ready = 1'b1;
    tick();
    mst_resp.aw_ready = 1'b0;
    mst_resp.b_valid = 1'b1; mst_resp.b.resp = 2'b01;
    tick();
    mst_resp.b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp b_valid held", 64'(slv_resp.b_valid), 64'd1);
      check("bp no extra aw", 64'(mst_req.aw_valid), 64'd0);
      tick();
    end
    b_take("bp", 8'h07, 2'b00);
    check("bp lite aw count", 64'(aw_hs - aw_base), 64'd1);

    // Concurrent write and read bursts, len 1 each.
    slv_req.aw.id = 8'h01; slv_req.aw.addr = 32'h5000; slv_req.aw.len = 8'd1;
    slv_req.aw.size = 3'd2; slv_req.aw.burst = 2'b01; slv_req.aw_valid = 1'b1;
    slv_req.ar.id = 8'h02; slv_req.ar.addr = 32'h6000; slv_req.ar.len = 8'd1;
    slv_req.ar.size = 3'd2; slv_req.ar.burst = 2'b01; slv_req.ar_valid = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0; slv_req.ar_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      settle();
      check("conc lite aw.addr", 64'(mst_req.aw.addr), 64'(32'h5000 + 32'(b) * 4));
      check("conc lite ar.addr", 64'(mst_req.ar.addr), 64'(32'h6000 + 32'(b) * 4));
      check("conc lite ar_valid", 64'(mst_req.ar_valid), 64'd1);
      slv_req.w_valid = 1'b1; mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
      mst_resp.ar_ready = 1'b1;
      tick();
      slv_req.w_valid = 1'b0; mst_resp.aw_ready = 1'b0; mst_resp.w_ready = 1'b0;
      mst_resp.ar_ready = 1'b0;
      mst_resp.b_valid = 1'b1; mst_resp.b.resp = (b == 1) ? 2'b11 : 2'b00;
      mst_resp.r_valid = 1'b1; mst_resp.r.data = 32'hA1 + 32'(b); slv_req.r_ready = 1'b1;
      settle();
      check("conc lite b_ready", 64'(mst_req.b_ready), 64'd1);
      check("conc r.data", 64'(slv_resp.r.data), 64'(32'hA1 + 32'(b)));
      check("conc r.id", 64'(slv_resp.r.id), 64'h02);
      check("conc r.last", 64'(slv_resp.r.last), 64'(b));
      tick();
      mst_resp.b_valid = 1'b0; mst_resp.r_valid = 1'b0; slv_req.r_ready = 1'b0;
    end
    b_take("conc", 8'h01, 2'b11);
    check("conc idle ar_ready", 64'(slv_resp.ar_ready), 64'd1);

    // Oversize read (size 3 on a 32-bit bus): two SLVERR beats, no lite AR.
    ar_base = ar_hs;
    ar_send(8'h09, 32'h7000, 8'd1, 3'd3, 2'b01);
    settle();
    check("ovr r_valid", 64'(slv_resp.r_valid), 64'd1);
    check("ovr r.resp", 64'(slv_resp.r.resp), 64'd2);
    check("ovr r.data", 64'(slv_resp.r.data), 64'd0);
    check("ovr r.last beat0", 64'(slv_resp.r.last), 64'd0);
    check("ovr r.id", 64'(slv_resp.r.id), 64'h09);
    check("ovr lite ar_valid", 64'(mst_req.ar_valid), 64'd0);
    slv_req.r_ready = 1'b1;
    tick();
    settle();
    check("ovr r.last beat1", 64'(slv_resp.r.last), 64'd1);
    check("ovr r.resp beat1", 64'(slv_resp.r.resp), 64'd2);
    tick();
    slv_req.r_ready = 1'b0;
    settle();
    check("ovr r_valid done", 64'(slv_resp.r_valid), 64'd0);
    check("ovr lite ar count", 64'(ar_hs - ar_base), 64'd0);

    // Oversize write: two W beats drained, SLVERR, no lite AW.
    aw_base = aw_hs;
    aw_send(8'h06, 32'h9000, 8'd1, 3'd3, 2'b01);
    slv_req.w_valid = 1'b1;
    settle();
    check("ovw w_ready", 64'(slv_resp.w_ready), 64'd1);
    check("ovw lite aw_valid", 64'(mst_req.aw_valid), 64'd0);
    tick();
    tick();
    slv_req.w_valid = 1'b0;
    b_take("ovw", 8'h06, 2'b10);
    check("ovw lite aw count", 64'(aw_hs - aw_base), 64'd0);

    // Reset in the middle of a len-3 write after its first lite B.
    aw_base = aw_hs;
    aw_send(8'h04, 32'h8000, 8'd3, 3'd2, 2'b01);
    wr_beat("rst0", 32'h8000, 32'hCAFE_0000, 2'b00);
    settle();
    check("rst beat1 aw.addr", 64'(mst_req.aw.addr), 64'h8004);
    rst_n = 1'b0;
    slv_req.w_valid = 1'b1; mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    settle();
    check("rst async handshakes", 64'(all_hs()), 64'd0);
    tick();
    check("rst held handshakes", 64'(all_hs()), 64'd0);
    slv_req.w_valid = 1'b0; mst_resp.aw_ready = 1'b0; mst_resp.w_ready = 1'b0;
    rst_n = 1'b1;
    settle();
    check("rst release aw_ready", 64'(slv_resp.aw_ready), 64'd1);
    check("rst release lite aw_valid", 64'(mst_req.aw_valid), 64'd0);
    check("rst lite aw count", 64'(aw_hs - aw_base), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_to_lite_splitter.md
AXI_TO_LITE_SPLITTER -- requirements
Module: axi_to_lite_splitter

Interface
REQ-001 SHALL have parameters: AxiAddrWidth, default 32, address width; AxiDataWidth, default 32, data width (32 or 64); AxiIdWidth, default 8, ID width; AxiUserWidth, default 8, user width; axi_req_t/axi_resp_t, full AXI4 request/response structs; lite_req_t/lite_resp_t, AXI-Lite request/response structs.
REQ-002 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset.
REQ-003 SHALL have ports: slv_req_i  in  axi_req_t  full AXI4 subordinate request; slv_resp_o  out  axi_resp_t  full AXI4 subordinate response.
REQ-004 SHALL have ports: mst_req_o  out  lite_req_t  AXI-Lite manager request; mst_resp_i  in  lite_resp_t  AXI-Lite manager response.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-006 SHALL convert each full-AXI burst into len+1 single AXI-Lite transactions, executed sequentially in beat order.
REQ-007 SHALL keep read and write paths independent, with one outstanding burst per path and concurrent read/write operation allowed.
REQ-008 Write FSM states SHALL be IDLE, BEAT, RESP, BRESP.
- IDLE: aw_ready=1. AW handshake latches id, addr, len, size, burst, prot; beat counter := 0; worst resp := OKAY; -> BEAT.
REQ-009 In BEAT, the block SHALL drive lite AW (current addr, latched prot) and lite W (forwarded from AXI W) and hold each valid until its own handshake.
- AXI w_ready = lite w_ready, gated to BEAT before the lite W handshake.
- Exits to RESP once both handshakes have completed, in either order or in the same cycle.
REQ-010 RESP SHALL assert lite b_ready, merge lite b.resp into worst resp (DECERR > SLVERR > OKAY), then:
- counter == len: -> BRESP.
- otherwise: counter+1, advance addr, -> BEAT.
REQ-011 BRESP SHALL drive AXI b_valid with latched id, worst resp and user=0, holding until b_ready, then -> IDLE.
REQ-012 Read FSM states SHALL be IDLE, AR, R.
- IDLE: ar_ready=1. AR handshake latches fields; -> AR.
- AR: drives lite AR until handshake; -> R.
REQ-013 In R, lite r_ready SHALL equal AXI r_ready and AXI r_valid SHALL equal lite r_valid, with data/resp passed through, id latched, user 0, r_last=(counter==len).
- On handshake: last beat -> IDLE; else counter+1, advance addr, -> AR.
REQ-014 Address advance SHALL follow the burst type, with step = 2^size:
- FIXED: address unchanged.
- INCR: next = aligned(addr) + step.
- WRAP: increment within the wrap boundary of (len+1)*step bytes, wrapping to the boundary base.
REQ-015 A burst with size > log2(AxiDataWidth/8) SHALL issue no lite transactions.
- Write: consume len+1 W beats, then return SLVERR.
- Read: return len+1 R beats with SLVERR, data 0, r_last on the final beat.
REQ-016 Beat count SHALL derive from len only; AXI w_last SHALL be ignored.
REQ-017 Latency SHALL be one cycle from an AXI AW/AR handshake to lite AW/AR valid.
- A new AXI AW/AR is accepted in the cycle after B/last-R completes (no bypass).
REQ-018 Lite AW/AR/W valid SHALL never drop before its handshake; AXI B/R valid likewise.
REQ-019 EXOKAY SHALL never be generated; a lite EXOKAY response is treated as OKAY.

Reset
REQ-020 While rst_ni=0, the block SHALL put both FSMs in IDLE, clear counters, addresses, IDs and worst resp, and drive all valids low.
- All readies low except aw_ready and ar_ready, which become 1 only after reset deasserts.
REQ-021 Reset asserted mid-burst SHALL abandon the burst immediately, with no further lite or AXI beats issued.

Verification
REQ-022 Single write: AW addr 0x1000, len 0, size 2, id 0x5; W data 0xDEADBEEF, strb 0xF; lite B OKAY -> one lite AW 0x1000, W 0xDEADBEEF/0xF; AXI B id 0x5 OKAY.
REQ-023 INCR write: len 3, size 2, addr 0x2000; lite B beat 2 SLVERR -> lite AW 0x2000, 0x2004, 0x2008, 0x200C; single AXI B SLVERR.
REQ-024 WRAP read: addr 0x3008, len 3, size 2, id 0x3 -> lite AR 0x3008, 0x300C, 0x3000, 0x3004; four R beats id 0x3, r_last only on the fourth.
REQ-025 Backpressure: lite aw_ready delayed 3 cycles, w_ready immediate, AXI b_ready low 5 cycles -> valids stable, exactly one lite write, B held until ready.
REQ-026 Concurrent read and write bursts (len 1 each) plus oversize read (size 3, 32-bit bus) -> interleaved lite traffic correct per path; oversize read gives two SLVERR beats with no lite AR.
REQ-027 Reset mid-write after the first lite B of a len-3 burst -> all valids low within the reset, IDLE with aw_ready=1 after release.
